// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice per clock through full_adder_4bits, LSB first.
// Optional signed-overflow output `ovf` is enabled by defining NIBBLE_ADDER_OVF_EN.

module full_adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s    = sum[3:0];
  assign cout = sum[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy
`ifdef NIBBLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [3:0]       nib;
  logic             nib_c;
  logic             accept, take, last;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign last     = (state == ADD) && (idx == LAST_IDX);

  full_adder_4bits u_fa (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .s    (nib),
    .cout (nib_c)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last)   state_nxt = DONE;
      DONE:    if (take)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: operand shift registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == ADD) begin
      a_sh <= a_sh >> 4;
      b_sh <= b_sh >> 4;
    end
  end

`ifdef NIBBLE_ADDER_OVF_EN
  logic msb_cin;

  // Carry into the top bit of the MSB nibble, recovered from its sum bit.
  assign msb_cin = a_sh[3] ^ b_sh[3] ^ nib[3];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      s     <= '0;
      carry <= cin;
      idx   <= '0;
    end else if (state == ADD) begin
      s[4*idx +: 4] <= nib;
      carry         <= nib_c;
      idx           <= idx + 1'b1;
      if (last) begin
        cout      <= nib_c;
        out_valid <= 1'b1;
`ifdef NIBBLE_ADDER_OVF_EN
        ovf       <= nib_c ^ msb_cin;
`endif
      end
    end else if (take) begin
      out_valid <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed literal cases plus
// randomized handshake traffic checked every cycle against an arithmetic model.

module tb_nibble_serial_adder;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] s;
  logic             cout, busy;
`ifdef NIBBLE_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
`ifdef NIBBLE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted operation yields a+b+cin, visible NIBBLES edges later,
  // held until the consumer takes it.
  bit               m_busy, m_valid, m_cout, m_ovf;
  int               m_left;
  logic [WIDTH-1:0] m_s;
  logic [WIDTH:0]   m_res;
  bit               m_res_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_left = 0;
      m_s = '0; m_cout = 0; m_ovf = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        int sa, sb, ss;
        m_res  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        sa     = int'($signed(a));
        sb     = int'($signed(b));
        ss     = sa + sb + int'(cin);
        m_res_ovf = (ss > 32767) || (ss < -32768);
        m_busy = 1;
        m_left = NIBBLES;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1;
        {m_cout, m_s} = m_res;
        m_ovf = m_res_ovf;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
      m_busy  = 0;
      m_ovf   = 0;
      n_done++;
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("busy", 32'(busy), 32'(m_busy));
      if (m_valid) begin
        check("s", 32'(s), 32'(m_s));
        check("cout", 32'(cout), 32'(m_cout));
`ifdef NIBBLE_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  // One directed operation with literal expectations; holds the result `hold` cycles while
  // presenting new operands that must be ignored.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input logic [15:0] es, input logic ec, input logic eovf, input int hold);
    int n;
    logic [15:0] s_hold;
    logic        c_hold;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1 n++; end
    check("latency", 32'(n), 32'(NIBBLES));
    check("lit_s", 32'(s), 32'(es));
    check("lit_cout", 32'(cout), 32'(ec));
`ifdef NIBBLE_ADDER_OVF_EN
    check("lit_ovf", 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("unused ovf expectation");
`endif
    s_hold = s;
    c_hold = cout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
      @(posedge clk);
      #1;
      check("hold_s", 32'(s), 32'(es));
      check("hold_cout", 32'(cout), 32'(ec));
      check("hold_in_ready", 32'(in_ready), 32'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    check("after_take_valid", 32'(out_valid), 32'(0));
    check("after_take_ready", 32'(in_ready), 32'(1));
    if (hold > 0) check("held_s_equal", 32'(s_hold), 32'(es));
    if (hold > 0) check("held_cout_equal", 32'(c_hold), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", 32'(s), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
`ifdef NIBBLE_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5);

    // Reset two edges into ADD abandons the operation immediately.
    while (!in_ready) @(negedge clk);
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_s", 32'(s), 32'(0));
    check("midrst_cout", 32'(cout), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    // Randomized traffic, including out_ready pulses while no result is pending.
    n_done = 0;
    repeat (2000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) == 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (NIBBLES + 3) @(negedge clk);
    out_ready = 1'b0;
    check("random_ops_completed", 32'(n_done > 20), 32'(1));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
